// File: rtl/spi7seg_pkg.sv
// Shared command encodings and frame layout for the SPI receive path and the
// seven-segment display stage.
package spi7seg_pkg;

  localparam logic [1:0] CMD_NOP     = 2'b00;
  localparam logic [1:0] CMD_BLINK   = 2'b01;
  localparam logic [1:0] CMD_DISPLAY = 2'b10;
  localparam logic [1:0] CMD_FLUSH   = 2'b11;

  localparam int unsigned FRAME_BITS = 6;

  typedef struct packed {
    logic [1:0] cmd;
    logic [3:0] data;
  } frame_t;

  // SHIFT means a partial frame is held (bit counter non-zero).
  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } rx_state_e;

  function automatic logic is_queued(input logic [1:0] cmd);
    return (cmd == CMD_DISPLAY) || (cmd == CMD_BLINK);
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Single-clock synchronous FIFO with flush; head is presented combinationally
// and reads as zero while empty.
module frame_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 6
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge sclk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_frame_fifo_rx.sv
// SPI mode-0 frame deserializer and command decoder feeding a frame FIFO
// towards the seven-segment display stage.
module spi_frame_fifo_rx #(
  parameter int unsigned FRAME_BITS = 6,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic                   ss,
  input  logic                   mosi,
  output logic                   frm_valid,
  input  logic                   frm_ready,
  output logic [1:0]             frm_cmd,
  output logic [3:0]             frm_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [3:0]             abort_cnt
);

  import spi7seg_pkg::*;

  localparam int unsigned CW = $clog2(FRAME_BITS);

  rx_state_e               state_q;
  rx_state_e               state_d;
  logic [CW-1:0]           bit_cnt;
  logic [FRAME_BITS-2:0]   shift_q;
  logic                    frame_done;
  logic                    abort;
  frame_t                  frame;
  logic                    push;
  logic                    flush;
  logic                    pop;
  logic                    full;
  logic                    empty;
  frame_t                  head;

  assign frame = frame_t'({shift_q, mosi});

  always_ff @(posedge sclk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ss || (bit_cnt == CW'(FRAME_BITS - 1))) state_d = ST_IDLE;
    else                                         state_d = ST_SHIFT;
  end

  always_comb begin
    frame_done = 1'b0;
    abort      = 1'b0;
    if (ss) abort      = (state_q == ST_SHIFT);
    else    frame_done = (bit_cnt == CW'(FRAME_BITS - 1));
  end

  always_ff @(posedge sclk) begin
    if (!rst_n || ss) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      shift_q <= {shift_q[FRAME_BITS-3:0], mosi};
      bit_cnt <= frame_done ? '0 : bit_cnt + CW'(1);
    end
  end

  assign push  = frame_done && is_queued(frame.cmd);
  assign flush = frame_done && (frame.cmd == CMD_FLUSH);
  assign pop   = frm_valid && frm_ready;

  frame_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(frame_t))
  ) u_fifo (
    .sclk  (sclk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (frame),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign frm_valid = !empty;
  assign frm_cmd   = head.cmd;
  assign frm_data  = head.data;

  always_ff @(posedge sclk) begin
    if (!rst_n || flush)            overflow <= 1'b0;
    else if (push && full && !pop)  overflow <= 1'b1;
  end

  always_ff @(posedge sclk) begin
    if (!rst_n)                        abort_cnt <= '0;
    else if (abort && abort_cnt != '1) abort_cnt <= abort_cnt + 4'd1;
  end

endmodule

// File: tb/tb_spi_frame_fifo_rx.sv
// Directed bench: stimulus pushes expected frames into a scoreboard queue and
// a negedge monitor checks every handshaked head against it.
module tb_spi_frame_fifo_rx;

  logic       sclk;
  logic       rst_n;
  logic       ss;
  logic       mosi;
  logic       frm_valid;
  logic       frm_ready;
  logic [1:0] frm_cmd;
  logic [3:0] frm_data;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [3:0] abort_cnt;

  int tests = 0;
  int fails = 0;
  logic [5:0] sb [$];

  spi_frame_fifo_rx #(
    .FRAME_BITS (6),
    .DEPTH      (4)
  ) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .ss         (ss),
    .mosi       (mosi),
    .frm_valid  (frm_valid),
    .frm_ready  (frm_ready),
    .frm_cmd    (frm_cmd),
    .frm_data   (frm_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .abort_cnt  (abort_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a head presented with ready high is consumed on the next edge.
  always @(negedge sclk) begin
    if (rst_n && frm_valid && frm_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", int'({frm_cmd, frm_data}), -1);
      end else begin
        check("sb_head", int'({frm_cmd, frm_data}), int'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic send_frame(input logic [5:0] f, input bit queued, input bit rdy_last);
    for (int i = 5; i >= 0; i--) begin
      ss   = 1'b0;
      mosi = f[i];
      if (i == 0 && rdy_last) frm_ready = 1'b1;
      tick();
    end
    if (queued) sb.push_back(f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ss = 1'b1;
      tick();
    end
  endtask

  task automatic abort_after(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ss   = 1'b0;
      mosi = 1'b1;
      tick();
    end
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ss = 1'b1; mosi = 1'b0; frm_ready = 1'b0;
    tick(); tick();
    check("rst_valid", frm_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_abort", abort_cnt, 0);
    check("rst_cmd", frm_cmd, 0);
    check("rst_data", frm_data, 0);
    rst_n = 1'b1;
    idle(1);

    // Single DISPLAY 5, visible right after its sixth edge.
    send_frame(6'h25, 1'b1, 1'b0);
    check("single_valid", frm_valid, 1);
    check("single_cmd", frm_cmd, 2);
    check("single_data", frm_data, 5);
    check("single_level", fifo_level, 1);
    frm_ready = 1'b1; idle(1); frm_ready = 1'b0;
    check("single_drained", fifo_level, 0);

    // Six back-to-back frames into a 4-deep FIFO.
    for (int d = 1; d <= 6; d++) send_frame(6'h20 | 6'(d), d <= 4, 1'b0);
    check("b2b_level", fifo_level, 4);
    check("b2b_overflow", overflow, 1);
    frm_ready = 1'b1; idle(5); frm_ready = 1'b0;
    check("b2b_empty_valid", frm_valid, 0);
    check("b2b_empty_level", fifo_level, 0);
    check("b2b_overflow_sticky", overflow, 1);
    send_frame(6'h30, 1'b0, 1'b0);
    check("flush_clears_ovf", overflow, 0);

    // Full FIFO, pop and push on the same edge.
    for (int d = 8; d <= 11; d++) send_frame(6'h20 | 6'(d), 1'b1, 1'b0);
    check("full_level", fifo_level, 4);
    send_frame(6'h27, 1'b1, 1'b1);
    frm_ready = 1'b0;
    check("pushpop_level", fifo_level, 4);
    check("pushpop_overflow", overflow, 0);
    check("pushpop_head", int'({frm_cmd, frm_data}), 6'h29);
    frm_ready = 1'b1; idle(4); frm_ready = 1'b0;
    check("pushpop_drained", fifo_level, 0);

    // Abort after 3 bits, then a clean BLINK.
    abort_after(3);
    send_frame(6'h10, 1'b1, 1'b0);
    check("abort_cnt_1", abort_cnt, 1);
    check("abort_level", fifo_level, 1);
    check("abort_blink_cmd", frm_cmd, 1);
    check("abort_blink_data", frm_data, 0);
    frm_ready = 1'b1; idle(1); frm_ready = 1'b0;
    for (int k = 0; k < 20; k++) abort_after((k % 5) + 1);
    check("abort_saturate", abort_cnt, 15);
    check("abort_nothing_queued", fifo_level, 0);

    // Flush wins over a simultaneous pop; NOP leaves everything alone.
    send_frame(6'h2C, 1'b1, 1'b0);
    send_frame(6'h2D, 1'b1, 1'b0);
    send_frame(6'h2E, 1'b1, 1'b0);
    send_frame(6'h2F, 1'b1, 1'b0);
    send_frame(6'h21, 1'b0, 1'b0);
    check("pre_flush_ovf", overflow, 1);
    frm_ready = 1'b1; idle(1); frm_ready = 1'b0;
    check("pre_flush_level", fifo_level, 3);
    send_frame(6'h3A, 1'b0, 1'b1);
    frm_ready = 1'b0;
    sb.delete();
    check("flush_level", fifo_level, 0);
    check("flush_valid", frm_valid, 0);
    check("flush_overflow", overflow, 0);
    send_frame(6'h0F, 1'b0, 1'b0);
    check("nop_level", fifo_level, 0);
    check("nop_valid", frm_valid, 0);

    // Reset mid-frame with two entries queued.
    send_frame(6'h22, 1'b1, 1'b0);
    send_frame(6'h23, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin ss = 1'b0; mosi = 1'b1; tick(); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    sb.delete();
    check("mid_rst_valid", frm_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_abort", abort_cnt, 0);
    check("mid_rst_cmd", frm_cmd, 0);
    check("mid_rst_data", frm_data, 0);
    send_frame(6'h29, 1'b1, 1'b0);
    check("post_rst_level", fifo_level, 1);
    check("post_rst_cmd", frm_cmd, 2);
    check("post_rst_data", frm_data, 9);
    frm_ready = 1'b1; idle(2); frm_ready = 1'b0;

    check("sb_empty_at_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
